// File: rtl/ej32_prefetch_if.sv
// rtl/ej32_prefetch_if.sv - memory read bus between the eJ32 prefetch queue and instruction memory
interface ej32_prefetch_if #(
  parameter int A_W = 17
);
  logic           mem_req;
  logic [A_W-1:0] mem_a;
  logic           mem_ack;
  logic [7:0]     mem_d;

  modport master (
    output mem_req,
    output mem_a,
    input  mem_ack,
    input  mem_d
  );

  modport slave (
    input  mem_req,
    input  mem_a,
    output mem_ack,
    output mem_d
  );
endinterface

// File: rtl/ej32_prefetch.sv
// rtl/ej32_prefetch.sv - eJ32 instruction byte prefetch queue with branch redirect
module ej32_prefetch #(
  parameter int             A_W   = 17,
  parameter logic [A_W-1:0] COLD  = '0,
  parameter int             DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [A_W-1:0]        flush_a,
  input  logic                  p_inc,
  output logic [7:0]            data,
  output logic                  vld,
  output logic [A_W-1:0]        pc,
  ej32_prefetch_if.master       bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [A_W-1:0] pc_q;
  logic [A_W-1:0] fa;
  logic [A_W-1:0] mem_a_q, mem_a_nxt;
  logic [PW-1:0]  head, tail;
  logic [CW-1:0]  count, count_nxt;
  logic [7:0]     queue [DEPTH];
  logic           push, pop, room;

  // Head byte and valid come straight from the queue; fetched data never bypasses it.
  assign vld         = (count != '0);
  assign data        = vld ? queue[head] : 8'h00;
  assign pc          = pc_q;
  assign bus.mem_a   = mem_a_q;
  assign bus.mem_req = (state == REQ) || (state == DROP);

  // Next state, request address and occupancy; a flush overrides any push or pop.
  always_comb begin
    state_nxt = state;
    mem_a_nxt = mem_a_q;
    push      = 1'b0;
    pop       = 1'b0;
    count_nxt = count;
    room      = 1'b0;
    if (flush) begin
      count_nxt = '0;
      case (state)
        IDLE: begin
          state_nxt = REQ;
          mem_a_nxt = flush_a;
        end
        REQ: begin
          if (bus.mem_ack) begin
            state_nxt = REQ;
            mem_a_nxt = flush_a;
          end else begin
            state_nxt = DROP;
          end
        end
        default: begin
          // A stale ack landing with the flush completes the drop immediately.
          if (bus.mem_ack) begin
            state_nxt = REQ;
            mem_a_nxt = flush_a;
          end else begin
            state_nxt = DROP;
          end
        end
      endcase
    end else begin
      pop       = p_inc && vld;
      push      = (state == REQ) && bus.mem_ack;
      count_nxt = count + CW'(push) - CW'(pop);
      room      = (count_nxt < CW'(DEPTH));
      case (state)
        IDLE: begin
          if (room) begin
            state_nxt = REQ;
            mem_a_nxt = fa;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            if (room) begin
              state_nxt = REQ;
              mem_a_nxt = fa + 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        default: begin
          if (bus.mem_ack) begin
            state_nxt = REQ;
            mem_a_nxt = fa;
          end
        end
      endcase
    end
  end

  // Queue storage, pointers and addresses; reset abandons any request in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      pc_q    <= COLD;
      fa      <= COLD;
      mem_a_q <= COLD;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        queue[i] <= 8'h00;
      end
    end else begin
      state   <= state_nxt;
      mem_a_q <= mem_a_nxt;
      count   <= count_nxt;
      if (flush) begin
        head <= tail;
        pc_q <= flush_a;
        fa   <= flush_a;
      end else begin
        if (push) begin
          queue[tail] <= bus.mem_d;
          tail        <= tail + 1'b1;
          fa          <= fa + 1'b1;
        end
        if (pop) begin
          head <= head + 1'b1;
          pc_q <= pc_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ej32_prefetch.sv
// tb/tb_ej32_prefetch.sv - scoreboard bench for the eJ32 prefetch queue
module tb_ej32_prefetch;

  localparam int A_W = 17;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           flush = 1'b0;
  logic           p_inc = 1'b0;
  logic [A_W-1:0] flush_a = '0;
  logic [7:0]     data;
  logic           vld;
  logic [A_W-1:0] pc;

  ej32_prefetch_if #(.A_W(A_W)) bus ();

  ej32_prefetch #(.A_W(A_W), .COLD('0), .DEPTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .flush_a (flush_a),
    .p_inc   (p_inc),
    .data    (data),
    .vld     (vld),
    .pc      (pc),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [A_W-1:0] a;
    logic [7:0]     d;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;
  int   lat  = 0;
  int   wcnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Memory returns mem_a[7:0] after lat wait cycles; ack is consumed at the next edge.
  task automatic mem_model();
    if (bus.mem_ack) wcnt = 0;
    if (bus.mem_req) begin
      if (wcnt >= lat) begin
        bus.mem_ack = 1'b1;
        bus.mem_d   = bus.mem_a[7:0];
      end else begin
        bus.mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      bus.mem_ack = 1'b0;
      wcnt = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    mem_model();
  endtask

  task automatic sb_load(input logic [A_W-1:0] base, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.a = base + A_W'(i);
      e.d = e.a[7:0];
      sb.push_back(e);
    end
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, 32'(data), 32'(e.d));
      chk({tag, "_pc"}, 32'(pc), 32'(e.a));
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    p_inc = 1'b0;
    flush = 1'b0;
    cycle();
    rst = 1'b1;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.mem_ack = 1'b0;
    bus.mem_d   = 8'h00;

    // 1: reset state, then four zero-wait fetches fill the queue
    lat = 0;
    rst = 1'b0;
    cycle();
    cycle();
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_a", 32'(bus.mem_a), 32'd0);
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    rst = 1'b1;
    sb_load('0, 24);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t1_req", 32'(bus.mem_req), 32'd1);
      chk("t1_a", 32'(bus.mem_a), 32'(i));
    end
    cycle();
    chk("t1_full_req", 32'(bus.mem_req), 32'd0);
    chk("t1_vld", 32'(vld), 32'd1);
    chk("t1_data", 32'(data), 32'h00);
    chk("t1_pc", 32'(pc), 32'd0);

    // 2: continuous consumption, one byte per cycle
    p_inc = 1'b1;
    for (int k = 0; k < 20; k++) begin
      chk("t2_vld", 32'(vld), 32'd1);
      sb_check("t2");
      if (k >= 1) chk("t2_req", 32'(bus.mem_req), 32'd1);
      cycle();
    end
    p_inc = 1'b0;

    // 3: flush while a slow request is outstanding forces a drop
    lat = 3;
    do_reset();
    cycle();
    chk("t3_req", 32'(bus.mem_req), 32'd1);
    flush = 1'b1;
    flush_a = 17'h100;
    sb_load(17'h100, 4);
    cycle();
    flush = 1'b0;
    chk("t3_drop_req", 32'(bus.mem_req), 32'd1);
    chk("t3_drop_a", 32'(bus.mem_a), 32'd0);
    chk("t3_drop_vld", 32'(vld), 32'd0);
    n = 0;
    while (!(bus.mem_req && bus.mem_a == 17'h100) && n < 30) begin
      cycle();
      n++;
    end
    chk("t3_newa_wait", 32'(n < 30), 32'd1);
    chk("t3_stale_vld", 32'(vld), 32'd0);
    n = 0;
    while (!vld && n < 30) begin
      cycle();
      n++;
    end
    chk("t3_vld_wait", 32'(n < 30), 32'd1);
    sb_check("t3a");
    p_inc = 1'b1;
    cycle();
    p_inc = 1'b0;
    n = 0;
    while (!vld && n < 30) begin
      cycle();
      n++;
    end
    chk("t3_vld2_wait", 32'(n < 30), 32'd1);
    sb_check("t3b");

    // 4: flush, ack and pop all in one cycle with two bytes queued
    lat = 0;
    do_reset();
    cycle();
    cycle();
    cycle();
    chk("t4_pre_a", 32'(bus.mem_a), 32'd2);
    chk("t4_pre_vld", 32'(vld), 32'd1);
    flush = 1'b1;
    flush_a = 17'h40;
    p_inc = 1'b1;
    sb.delete();
    sb_load(17'h40, 2);
    cycle();
    flush = 1'b0;
    p_inc = 1'b0;
    chk("t4_vld", 32'(vld), 32'd0);
    chk("t4_req", 32'(bus.mem_req), 32'd1);
    chk("t4_a", 32'(bus.mem_a), 32'h40);
    cycle();
    chk("t4_vld2", 32'(vld), 32'd1);
    sb_check("t4");

    // 5: flush from a full queue near the top of the address space
    n = 0;
    while (bus.mem_req && n < 30) begin
      cycle();
      n++;
    end
    chk("t5_full_wait", 32'(n < 30), 32'd1);
    flush = 1'b1;
    flush_a = 17'h1FFFE;
    sb.delete();
    sb_load(17'h1FFFE, 8);
    cycle();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [A_W-1:0] ea;
      ea = 17'h1FFFE + A_W'(i);
      chk("t5_a", 32'(bus.mem_a), 32'(ea));
      chk("t5_req", 32'(bus.mem_req), 32'd1);
      cycle();
    end
    chk("t5_full_req", 32'(bus.mem_req), 32'd0);
    p_inc = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("t5_vld", 32'(vld), 32'd1);
      sb_check("t5");
      cycle();
    end
    p_inc = 1'b0;

    // 6: reset mid-request, then a pop attempt on an empty queue
    lat = 3;
    flush = 1'b1;
    flush_a = 17'h200;
    cycle();
    flush = 1'b0;
    chk("t6_req", 32'(bus.mem_req), 32'd1);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    chk("t6_rst_req", 32'(bus.mem_req), 32'd0);
    chk("t6_rst_vld", 32'(vld), 32'd0);
    chk("t6_rst_pc", 32'(pc), 32'd0);
    chk("t6_rst_a", 32'(bus.mem_a), 32'd0);
    p_inc = 1'b1;
    cycle();
    p_inc = 1'b0;
    chk("t6_pc_hold", 32'(pc), 32'd0);
    chk("t6_vld", 32'(vld), 32'd0);
    chk("t6_req2", 32'(bus.mem_req), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
